// File: rtl/bird_flight_if.sv
// bird_flight_if: control inputs and bird state outputs for the flight engine
interface bird_flight_if;
  logic       Start;
  logic       Ack;
  logic       BtnPress;
  logic       Lose;
  logic [9:0] Bird_Y;
  logic [9:0] VertSpeed;
  logic       Frame_Tick;
  logic       q_Initial;
  logic       q_Fly;
  logic       q_Dead;
  modport master (
    output Start, Ack, BtnPress, Lose,
    input  Bird_Y, VertSpeed, Frame_Tick, q_Initial, q_Fly, q_Dead
  );
  modport slave (
    input  Start, Ack, BtnPress, Lose,
    output Bird_Y, VertSpeed, Frame_Tick, q_Initial, q_Fly, q_Dead
  );
endinterface

// File: rtl/bird_flight.sv
// bird_flight: bird vertical physics with self-generated frame tick and INITIAL/FLY/DEAD phases
module bird_flight #(
  parameter int TICK_DIV = 1666667,
  parameter int Y_INIT   = 240,
  parameter int Y_TOP    = 0,
  parameter int Y_GROUND = 464,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = -8,
  parameter int MAX_FALL = 10
) (
  input logic         board_clk,
  input logic         Reset,
  bird_flight_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] L_LAST = CW'(TICK_DIV - 1);
  localparam logic signed [11:0] L_GRAV = 12'(GRAVITY);
  localparam logic signed [11:0] L_FLAP = 12'(FLAP_VEL);
  localparam logic signed [11:0] L_MAX  = 12'(MAX_FALL);
  localparam logic signed [11:0] L_TOP  = 12'(Y_TOP);
  localparam logic signed [11:0] L_GND  = 12'(Y_GROUND);
  typedef enum logic [2:0] {S_INIT = 3'b001, S_FLY = 3'b010, S_DEAD = 3'b100} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_tick, r_btn, r_flap, w_edge, w_flap;
  logic [9:0] r_y, r_v, w_y, w_v;
  logic signed [11:0] w_vs, w_vg, w_vn, w_ys, w_yn;
  assign w_edge = bus.BtnPress & ~r_btn;
  assign w_flap = r_flap | w_edge;
  // physics in 12-bit signed so ceiling overshoot and ground overshoot are both visible
  assign w_vs = {{2{r_v[9]}}, r_v};
  assign w_vg = w_vs + L_GRAV;
  assign w_vn = w_flap ? L_FLAP : (w_vg > L_MAX ? L_MAX : w_vg);
  assign w_ys = {2'b00, r_y};
  assign w_yn = w_ys + w_vn;
  always_ff @(posedge board_clk) begin
    if (!Reset) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_btn   <= 1'b0;
      r_flap  <= 1'b0;
      r_y     <= 10'(Y_INIT);
      r_v     <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_cnt == L_LAST) ? '0 : r_cnt + CW'(1);
      r_tick  <= (r_cnt == L_LAST);
      r_btn   <= bus.BtnPress;
      r_flap  <= (r_state == S_FLY) && !r_tick && w_flap;
      r_y     <= w_y;
      r_v     <= w_v;
    end
  end
  always_comb begin
    w_next = r_state;
    w_y    = r_y;
    w_v    = r_v;
    case (r_state)
      S_INIT: begin
        w_y = 10'(Y_INIT);
        w_v = '0;
        if (bus.Start) w_next = S_FLY;
      end
      S_FLY: begin
        if (bus.Lose) w_next = S_DEAD;
        else if (r_tick) begin
          if (w_yn <= L_TOP) begin
            w_y = 10'(Y_TOP);
            w_v = '0;
          end else if (w_yn >= L_GND) begin
            w_y    = 10'(Y_GROUND);
            w_v    = '0;
            w_next = S_DEAD;
          end else begin
            w_y = w_yn[9:0];
            w_v = w_vn[9:0];
          end
        end
      end
      S_DEAD: begin
        if (bus.Ack) begin
          w_next = S_INIT;
          w_y    = 10'(Y_INIT);
          w_v    = '0;
        end
      end
      default: w_next = S_INIT;
    endcase
  end
  assign bus.Bird_Y     = r_y;
  assign bus.VertSpeed  = r_v;
  assign bus.Frame_Tick = r_tick;
  assign bus.q_Initial  = r_state[0];
  assign bus.q_Fly      = r_state[1];
  assign bus.q_Dead     = r_state[2];
endmodule
